// File: rtl/sub_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the nibble-serial subtractor.
// Pure declarations: no latency and no backpressure of their own.
package sub_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic int num_nibbles(input int width);
    return width / NIBBLE;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(num_nibbles(width));
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Requester-side start/busy/done bundle with operands and result.
// The handshake has no backpressure: start is ignored while busy.
interface serial_sub_ctrl_if #(parameter int WIDTH = 16);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (output start, a, b, b_in, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, b_in, output busy, done, diff, borrow_out);

endinterface

// File: rtl/nibble_sub.sv
// 4-bit ripple-borrow subtractor built from a chain of full subtractors.
// Latency: purely combinational. Backpressure: none.
module nibble_sub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       b_in,
  output logic [3:0] diff,
  output logic       borrow
);

  logic [4:0] c;

  assign c[0] = b_in;

  for (genvar i = 0; i < 4; i++) begin : g_fs
    assign diff[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i]);
  end

  assign borrow = c[4];

endmodule

// File: rtl/serial_sub_ctrl.sv
// Computes a - b - b_in one nibble per cycle, LSB nibble first, on a single 4-bit subtractor.
// Latency: WIDTH/4 cycles accept-to-done. Backpressure: none; start is ignored while busy.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_sub_ctrl_if.slave    bus
);

  localparam int N  = num_nibbles(WIDTH);
  localparam int CW = cnt_width(WIDTH);

  if ((WIDTH % NIBBLE) != 0 || WIDTH < 8) begin : g_bad_width
    $error("serial_sub_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] diff_q;
  logic             brw;
  logic             bout_q;
  logic             done_q;
  logic [3:0]       nib_diff;
  logic             nib_brw;
  logic             accept;
  logic             last;

  nibble_sub u_nib (
    .a      (a_sh[3:0]),
    .b      (b_sh[3:0]),
    .b_in   (brw),
    .diff   (nib_diff),
    .borrow (nib_brw)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(N - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      brw    <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        a_sh <= bus.a;
        b_sh <= bus.b;
        brw  <= bus.b_in;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> NIBBLE;
        b_sh   <= b_sh >> NIBBLE;
        res_sh <= {nib_diff, res_sh[WIDTH-1:NIBBLE]};
        brw    <= nib_brw;
        cnt    <= cnt + 1'b1;
      end
      // The final nibble is still on the subtractor output, so splice it in directly.
      if (last) begin
        diff_q <= {nib_diff, res_sh[WIDTH-1:NIBBLE]};
        bout_q <= nib_brw;
      end
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl at WIDTH=16.
module tb_serial_sub_ctrl;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  serial_sub_ctrl_if #(.WIDTH(W)) bus ();

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operation, scramble the operand inputs, and check the full completion.
  task automatic do_op(input vec_t v, input string name);
    int j;
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = v.a;
    bus.b     = v.b;
    bus.b_in  = v.b_in;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~v.a;
    bus.b     = v.b ^ 16'h5A5A;
    bus.b_in  = ~v.b_in;
    j = 0;
    busy_cnt = 0;
    while (!bus.done && j < 20) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      j++;
    end
    check({name, " latency"}, j, 4);
    check({name, " busy_cycles"}, busy_cnt, 4);
    check({name, " busy_at_done"}, {31'd0, bus.busy}, 0);
    check({name, " diff"}, {16'd0, bus.diff}, {16'd0, v.exp_diff});
    check({name, " borrow_out"}, {31'd0, bus.borrow_out}, {31'd0, v.exp_bout});
    @(negedge clk);
    check({name, " done_one_pulse"}, {31'd0, bus.done}, 0);
  endtask

  initial begin
    int j;
    int extra_done;
    int held_ok;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.b_in  = 1'b0;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vecs[2] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h5555, 16'hAAAA, 1'b0, 16'hAAAB, 1'b1};
    vecs[5] = '{16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0};
    vecs[6] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", {31'd0, bus.busy}, 0);
    check("reset done", {31'd0, bus.done}, 0);
    check("reset diff", {16'd0, bus.diff}, 0);
    check("reset borrow_out", {31'd0, bus.borrow_out}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // start pulsed during RUN cycle 2 must be ignored entirely
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h00FF; bus.b = 16'h000F; bus.b_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h1111;
    @(negedge clk);
    bus.start = 1'b0;
    j = 2;
    while (!bus.done && j < 20) begin
      @(negedge clk);
      j++;
    end
    check("ignore latency", j, 4);
    check("ignore diff", {16'd0, bus.diff}, 32'h00F0);
    check("ignore borrow_out", {31'd0, bus.borrow_out}, 0);
    extra_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra_done++;
    end
    check("ignore no_second_op", extra_done, 0);

    // start held on the done cycle is accepted immediately
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h0234; bus.b_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    j = 0;
    while (!bus.done && j < 20) begin
      @(negedge clk);
      j++;
    end
    check("b2b first latency", j, 4);
    check("b2b first diff", {16'd0, bus.diff}, 32'h1000);
    bus.start = 1'b1; bus.a = 16'h0000; bus.b = 16'h0001; bus.b_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 16'h7777; bus.b = 16'h2222;
    check("b2b accepted busy", {31'd0, bus.busy}, 1);
    j = 0;
    held_ok = 1;
    while (!bus.done && j < 20) begin
      if (bus.diff !== 16'h1000) held_ok = 0;
      @(negedge clk);
      j++;
    end
    check("b2b diff held", held_ok, 1);
    check("b2b second latency", j, 4);
    check("b2b second diff", {16'd0, bus.diff}, 32'hFFFF);
    check("b2b second borrow_out", {31'd0, bus.borrow_out}, 1);

    // reset during RUN cycle 3 aborts without a done
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h0234; bus.b_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort busy", {31'd0, bus.busy}, 0);
    check("abort done", {31'd0, bus.done}, 0);
    check("abort diff", {16'd0, bus.diff}, 0);
    check("abort borrow_out", {31'd0, bus.borrow_out}, 0);
    rst_n = 1'b1;
    extra_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    check("abort no_done", extra_done, 0);
    do_op(vecs[4], "after_abort");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
